// File: rtl/cond_flag_pkg.sv
// Shared definitions for the registered condition-flag qualifier.
//   MODE_LEVEL / MODE_PULSE : values for the MODE parameter
//   clog2                   : counter width helper (never returns less than 1)
package cond_flag_pkg;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cond_flag_chan.sv
// One qualifier channel: din/en delay lines, consecutive-cycle counter and
// registered flag. The condition is formed only from the last delay stage,
// so the flag never sees a combinational path from the raw inputs.
// Ports:
//   clk, rst       clock, async active-high reset
//   clr            synchronous clear of counter and flag (delay line keeps shifting)
//   en, din        raw channel inputs
//   flag_nxt       next-state flag, used by the top for flag_any
//   flag           registered flag
module cond_flag_chan
  import cond_flag_pkg::*;
#(
  parameter int DLY  = 1,
  parameter int HOLD = 1,
  parameter int MODE = MODE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic flag_nxt,
  output logic flag
);

  localparam int CW = clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW:0]   HOLD_X = (CW + 1)'(HOLD);

  logic [DLY-1:0] din_sr_q, din_sr_d;
  logic [DLY-1:0] en_sr_q, en_sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           flag_q, flag_d;
  logic           cond;
  logic [CW:0]    cnt_inc;
  logic           reach;

  always_comb begin
    din_sr_d    = din_sr_q;
    en_sr_d     = en_sr_q;
    din_sr_d[0] = din;
    en_sr_d[0]  = en;
    for (int k = 1; k < DLY; k++) begin
      din_sr_d[k] = din_sr_q[k-1];
      en_sr_d[k]  = en_sr_q[k-1];
    end

    cond    = din_sr_q[DLY-1] & en_sr_q[DLY-1];
    // cnt+1 compared against HOLD is cnt compared against HOLD-1 without
    // underflow or a constant compare when HOLD=1.
    cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

    if (MODE == MODE_LEVEL) reach = (cnt_inc >= HOLD_X);
    else                    reach = (cnt_inc == HOLD_X);

    cnt_d = cnt_q;
    if (clr || !cond)        cnt_d = '0;
    else if (cnt_q < HOLD_C) cnt_d = cnt_q + CW'(1);

    flag_d = !clr && cond && reach;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_sr_q <= '0;
      en_sr_q  <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      din_sr_q <= din_sr_d;
      en_sr_q  <= en_sr_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
    end
  end

  assign flag_nxt = flag_d;
  assign flag     = flag_q;

endmodule

// File: rtl/cond_flag_qual.sv
// Multi-channel registered AND-flag qualifier. Each channel flags once its
// delayed din&en has held for HOLD consecutive cycles (level or pulse).
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        synchronous clear of all counters, flags and flag_any
//   en, din    per-channel inputs [CH-1:0]
//   flag       per-channel registered flags [CH-1:0]
//   flag_any   registered OR of flags, aligned with the flags themselves
module cond_flag_qual
  import cond_flag_pkg::*;
#(
  parameter int CH   = 4,
  parameter int DLY  = 1,
  parameter int HOLD = 1,
  parameter int MODE = MODE_LEVEL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] flag,
  output logic          flag_any
);

  logic [CH-1:0] flag_nxt;
  logic          flag_any_q, flag_any_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    cond_flag_chan #(
      .DLY  (DLY),
      .HOLD (HOLD),
      .MODE (MODE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en[i]),
      .din      (din[i]),
      .flag_nxt (flag_nxt[i]),
      .flag     (flag[i])
    );
  end

  // Built from next-state flags so flag_any rises on the same edge as the flag.
  always_comb begin
    flag_any_d = !clr && (|flag_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_any_q <= 1'b0;
    else     flag_any_q <= flag_any_d;
  end

  assign flag_any = flag_any_q;

endmodule

// File: tb/tb_cond_flag_qual.sv
module tb_cond_flag_qual;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] en  = '0;
  logic [3:0] din = '0;
  logic [3:0] flag_l, flag_p;
  logic       any_l, any_p;

  int chk_n = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] fl;
    logic       al;
    logic [3:0] fp;
    logic       ap;
  } exp_t;

  exp_t sb[$];
  logic [3:0] hist_r[$];
  logic       hist_c[$];

  always #5 clk = ~clk;

  cond_flag_qual #(.CH(4), .DLY(2), .HOLD(3), .MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din),
    .flag(flag_l), .flag_any(any_l));

  cond_flag_qual #(.CH(4), .DLY(1), .HOLD(2), .MODE(1)) u_pls (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din),
    .flag(flag_p), .flag_any(any_p));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Window model: after edge k a channel is flagged when its raw sample
  // (din&en) at edges k-dly-hold+1 .. k-dly was 1 and no clr fell on edges
  // k-hold+1 .. k. Pulse mode additionally needs the run to have been broken
  // at edge k-hold. Edges before reset release count as broken.
  function automatic logic cond_at(int j, int ch, int dly);
    int s;
    s = j - dly;
    if (s < 0) return 1'b0;
    return hist_r[s][ch];
  endfunction

  function automatic logic clr_at(int j);
    if (j < 0) return 1'b1;
    return hist_c[j];
  endfunction

  function automatic logic model(int k, int ch, int dly, int hold, int mode);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < hold; i++)
      if (!cond_at(k - i, ch, dly) || clr_at(k - i)) ok = 1'b0;
    if (mode == 1 && ok)
      if (cond_at(k - hold, ch, dly) && !clr_at(k - hold)) ok = 1'b0;
    return ok;
  endfunction

  task automatic step(input logic c, input logic [3:0] e, input logic [3:0] d);
    exp_t x;
    int k;
    clr = c; en = e; din = d;
    @(posedge clk);
    hist_r.push_back(e & d);
    hist_c.push_back(c);
    k = hist_r.size() - 1;
    for (int ch = 0; ch < 4; ch++) begin
      x.fl[ch] = model(k, ch, 2, 3, 0);
      x.fp[ch] = model(k, ch, 1, 2, 1);
    end
    x.al = |x.fl;
    x.ap = |x.fp;
    sb.push_back(x);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk("lvl_flag", 32'(flag_l), 32'(x.fl));
      chk("lvl_any",  32'(any_l),  32'(x.al));
      chk("pls_flag", 32'(flag_p), 32'(x.fp));
      chk("pls_any",  32'(any_p),  32'(x.ap));
    end
  end

  initial begin
    int lat_l, lat_p, cnt_a, cnt_b, first_l3, first_p3;
    int first_l[4];
    logic glitch_seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Latency: ch0 level flag after E+4, pulse after E+2.
    lat_l = -1; lat_p = -1;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 4'b0001, 4'b0001);
      if (lat_p < 0 && flag_p[0]) lat_p = n;
      if (flag_l[0]) begin lat_l = n; break; end
    end
    chk("latency_lvl", 32'(lat_l), 32'd4);
    chk("latency_pls", 32'(lat_p), 32'd2);
    repeat (3) step(1'b0, 4'b0001, 4'b0001);
    repeat (4) step(1'b0, 4'b0001, 4'b0000);

    // Glitch rejection on ch1: 2 high, 1 low, 2 high.
    glitch_seen = 1'b0;
    foreach (hist_r[i]) ; // no-op keeps history intact
    for (int n = 0; n < 8; n++) begin
      logic b;
      b = (n == 0 || n == 1 || n == 3 || n == 4);
      step(1'b0, {2'b00, b, 1'b0}, {2'b00, b, 1'b0});
      glitch_seen |= flag_l[1];
    end
    chk("glitch_lvl", 32'(glitch_seen), 32'd0);

    // Pulse mode on ch2: 8 held -> one pulse; 1 low then 4 high -> one more.
    cnt_a = 0; cnt_b = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 4'b0100, 4'b0100);
      cnt_a += int'(flag_p[2]);
    end
    step(1'b0, 4'b0100, 4'b0000);
    cnt_a += int'(flag_p[2]);
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 4'b0100, 4'b0100);
      cnt_b += int'(flag_p[2]);
    end
    repeat (3) begin
      step(1'b0, 4'b0000, 4'b0000);
      cnt_b += int'(flag_p[2]);
    end
    chk("pulse_count_1", 32'(cnt_a), 32'd1);
    chk("pulse_count_2", 32'(cnt_b), 32'd1);

    // clr on the level qualifying edge of ch3.
    first_l3 = -1; cnt_a = 0;
    for (int n = 0; n < 10; n++) begin
      step(n == 4, 4'b1000, 4'b1000);
      if (first_l3 < 0 && flag_l[3]) first_l3 = n;
      cnt_a += int'(flag_p[3]);
    end
    chk("clr_lvl_first", 32'(first_l3), 32'd7);
    chk("clr_pls_count", 32'(cnt_a), 32'd2);
    repeat (2) step(1'b0, 4'b0000, 4'b0000);

    // clr on the pulse qualifying edge of ch3.
    first_p3 = -1; cnt_a = 0;
    for (int n = 0; n < 8; n++) begin
      step(n == 2, 4'b1000, 4'b1000);
      if (first_p3 < 0 && flag_p[3]) first_p3 = n;
      cnt_a += int'(flag_p[3]);
    end
    chk("clr_pls_first", 32'(first_p3), 32'd4);
    chk("clr_pls_once", 32'(cnt_a), 32'd1);
    repeat (4) step(1'b0, 4'b0000, 4'b0000);

    // Staggered channels.
    for (int i = 0; i < 4; i++) first_l[i] = -1;
    for (int n = 0; n < 14; n++) begin
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (n >= i) && (n < i + 7);
      step(1'b0, v, v);
      for (int i = 0; i < 4; i++)
        if (first_l[i] < 0 && flag_l[i]) first_l[i] = n;
    end
    for (int i = 0; i < 4; i++) chk("stagger_first", 32'(first_l[i]), 32'(i + 4));

    // Mid-stream reset with everything qualified.
    repeat (6) step(1'b0, 4'b1111, 4'b1111);
    chk("pre_rst_lvl", 32'(flag_l), 32'hf);
    #2 rst = 1'b1;
    #1;
    chk("rst_lvl_flag", 32'(flag_l), 32'd0);
    chk("rst_lvl_any",  32'(any_l),  32'd0);
    chk("rst_pls_flag", 32'(flag_p), 32'd0);
    chk("rst_pls_any",  32'(any_p),  32'd0);
    repeat (3) begin
      @(negedge clk);
      en = 4'($urandom); din = 4'($urandom);
    end
    en = 4'hf; din = 4'hf;
    @(negedge clk);
    hist_r.delete();
    hist_c.delete();
    rst = 1'b0;
    lat_l = -1;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 4'b1111, 4'b1111);
      if (lat_l < 0 && flag_l[0]) lat_l = n;
    end
    chk("post_rst_latency", 32'(lat_l), 32'd4);

    // Mixed tail.
    for (int n = 0; n < 60; n++)
      step(($urandom % 8) == 0, 4'($urandom | $urandom), 4'($urandom | $urandom));
    repeat (5) step(1'b0, 4'b0000, 4'b0000);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
